// File: rtl/order_pkg.sv
// rtl/order_pkg.sv - shared states, constants and saturation helper for order_checker
package order_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COMPARE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [11:0] DISH_EMPTY  = 12'h000;
    localparam int          DEF_SCORE_W = 8;
    localparam int          MISS_W      = 4;
    localparam logic [MISS_W-1:0] MISS_SAT = 4'hF;

    function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] m);
        return (m == MISS_SAT) ? m : m + 4'd1;
    endfunction

endpackage

// File: rtl/order_checker_if.sv
// rtl/order_checker_if.sv - menu/dish/submit inputs and judgement outputs of order_checker
interface order_checker_if
    import order_pkg::*;
#(
    parameter int DISH_W  = 12,
    parameter int SCORE_W = DEF_SCORE_W
);
    logic              menu_valid;
    logic [DISH_W-1:0] menu_1;
    logic [DISH_W-1:0] menu_2;
    logic [DISH_W-1:0] menu_3;
    logic [DISH_W-1:0] dish;
    logic              submit;

    logic [2:0]         served;
    logic [SCORE_W-1:0] score;
    logic [MISS_W-1:0]  misses;
    logic               result_valid;
    logic               result_hit;
    logic               busy;
    logic               round_done;
    logic               round_win;
    logic               timed_out;

    modport master (
        output menu_valid, menu_1, menu_2, menu_3, dish, submit,
        input  served, score, misses, result_valid, result_hit,
               busy, round_done, round_win, timed_out
    );

    modport slave (
        input  menu_valid, menu_1, menu_2, menu_3, dish, submit,
        output served, score, misses, result_valid, result_hit,
               busy, round_done, round_win, timed_out
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, stable-high debounce and one-shot press event
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic basys_clk,
    input  logic reset,
    input  logic btn_i,
    output logic event_o
);
    logic [1:0]  sync_q;
    logic [31:0] cnt_q;
    logic        level_q;
    logic        level_d1_q;

    // Level only rises after DEBOUNCE_CYCLES consecutive synchronised-high samples.
    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b00;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_i};
            level_d1_q <= level_q;
            if (!sync_q[1]) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 1) begin
                level_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign event_o = level_q & ~level_d1_q;

endmodule

// File: rtl/order_checker.sv
// rtl/order_checker.sv - judges submitted dishes against the round's three orders; ORDER_TIMEOUT_EN adds a round timer
module order_checker
    import order_pkg::*;
#(
    parameter int          DISH_W          = 12,
    parameter int          SCORE_W         = DEF_SCORE_W,
    parameter int          MAX_MISSES      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 2_000_000_000
) (
    input  logic             basys_clk,
    input  logic             reset,
    order_checker_if.slave   bus
);
    localparam logic [DISH_W-1:0] EMPTY = DISH_W'(DISH_EMPTY);

    state_t             state_q, state_d;
    logic [DISH_W-1:0]  menu_q [3];
    logic [DISH_W-1:0]  menu_d [3];
    logic [DISH_W-1:0]  dish_q, dish_d;
    logic [2:0]         served_q, served_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  misses_q, misses_d;
    logic               result_valid_q, result_valid_d;
    logic               result_hit_q, result_hit_d;
    logic               round_win_q, round_win_d;
    logic [31:0]        hold_cnt_q, hold_cnt_d;
    logic               hit;
    logic               submit_ev;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .basys_clk (basys_clk),
        .reset     (reset),
        .btn_i     (bus.submit),
        .event_o   (submit_ev)
    );

`ifdef ORDER_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic        timed_out_q, timed_out_d;
`endif

    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            menu_q         <= '{default: '0};
            dish_q         <= '0;
            served_q       <= 3'b000;
            score_q        <= '0;
            misses_q       <= '0;
            result_valid_q <= 1'b0;
            result_hit_q   <= 1'b0;
            round_win_q    <= 1'b0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            menu_q         <= menu_d;
            dish_q         <= dish_d;
            served_q       <= served_d;
            score_q        <= score_d;
            misses_q       <= misses_d;
            result_valid_q <= result_valid_d;
            result_hit_q   <= result_hit_d;
            round_win_q    <= round_win_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

`ifdef ORDER_TIMEOUT_EN
    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            timer_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        menu_d         = menu_q;
        dish_d         = dish_q;
        served_d       = served_q;
        score_d        = score_q;
        misses_d       = misses_q;
        result_valid_d = 1'b0;
        result_hit_d   = result_hit_q;
        round_win_d    = round_win_q;
        hold_cnt_d     = hold_cnt_q;
        hit            = 1'b0;
`ifdef ORDER_TIMEOUT_EN
        timer_d        = timer_q;
        timed_out_d    = timed_out_q;
`endif

        // A new menu overrides whatever the round was doing, including a same-cycle press.
        if (bus.menu_valid) begin
            menu_d[0]    = bus.menu_1;
            menu_d[1]    = bus.menu_2;
            menu_d[2]    = bus.menu_3;
            served_d     = {bus.menu_3 == EMPTY, bus.menu_2 == EMPTY, bus.menu_1 == EMPTY};
            misses_d     = '0;
            result_hit_d = 1'b0;
            round_win_d  = 1'b0;
            if (bus.menu_1 == EMPTY && bus.menu_2 == EMPTY && bus.menu_3 == EMPTY) begin
                state_d     = ST_DONE;
                round_win_d = 1'b1;
            end else begin
                state_d = ST_ARMED;
            end
        end else begin
            unique case (state_q)
                ST_ARMED: begin
                    if (submit_ev) begin
                        dish_d  = bus.dish;
                        state_d = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    for (int i = 0; i < 3; i++) begin
                        if (!hit && dish_q != EMPTY && !served_q[i] && dish_q == menu_q[i]) begin
                            served_d[i] = 1'b1;
                            hit         = 1'b1;
                        end
                    end
                    if (hit) begin
                        score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    end else begin
                        misses_d = miss_inc(misses_q);
                    end
                    result_valid_d = 1'b1;
                    result_hit_d   = hit;
                    hold_cnt_d     = '0;
                    state_d        = ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_CYCLES - 1) begin
                        if (served_q == 3'b111) begin
                            state_d     = ST_DONE;
                            round_win_d = 1'b1;
                        end else if (misses_q >= MISS_W'(MAX_MISSES)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end

`ifdef ORDER_TIMEOUT_EN
        // Timeout wins over the HOLD exit but the judged result above still lands.
        if (bus.menu_valid) begin
            timer_d     = '0;
            timed_out_d = 1'b0;
        end else if (state_q == ST_ARMED || state_q == ST_COMPARE || state_q == ST_HOLD) begin
            if (timer_q == TIMEOUT_CYCLES - 1) begin
                state_d     = ST_DONE;
                round_win_d = 1'b0;
                timed_out_d = 1'b1;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end
`endif
    end

    assign bus.served       = served_q;
    assign bus.score        = score_q;
    assign bus.misses       = misses_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_hit   = result_hit_q;
    assign bus.busy         = (state_q == ST_COMPARE) || (state_q == ST_HOLD);
    assign bus.round_done   = (state_q == ST_DONE);
    assign bus.round_win    = round_win_q;
`ifdef ORDER_TIMEOUT_EN
    assign bus.timed_out    = timed_out_q;
`else
    logic unused_timeout;
    assign unused_timeout   = ^TIMEOUT_CYCLES;
    assign bus.timed_out    = 1'b0;
`endif

endmodule

// File: tb/tb_order_checker.sv
// tb/tb_order_checker.sv - scoreboard bench for order_checker
module tb_order_checker;

    typedef struct {
        logic       hit;
        logic [2:0] served;
        logic [7:0] score;
        logic [3:0] misses;
    } exp_t;

    logic basys_clk = 1'b0;
    logic reset     = 1'b1;

    int errors = 0;
    int checks = 0;
    int ev_lat = 6;

    exp_t        sb_q[$];
    logic [11:0] m [3];
    logic [2:0]  exp_served = 3'b000;
    logic [7:0]  exp_score  = 8'd0;
    logic [3:0]  exp_misses = 4'd0;

    order_checker_if #(.DISH_W(12), .SCORE_W(8)) bus ();

    order_checker #(
        .DISH_W          (12),
        .SCORE_W         (8),
        .MAX_MISSES      (3),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .TIMEOUT_CYCLES  (200)
    ) dut (
        .basys_clk (basys_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 basys_clk = ~basys_clk;

    task automatic step();
        @(posedge basys_clk);
        #1;
    endtask

    task automatic model_judge(input logic [11:0] d);
        exp_t e;
        e.hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!e.hit && d != 12'h000 && !exp_served[i] && d == m[i]) begin
                exp_served[i] = 1'b1;
                e.hit         = 1'b1;
            end
        end
        if (e.hit) exp_score  = (exp_score == 8'hFF) ? exp_score : exp_score + 8'd1;
        else       exp_misses = (exp_misses == 4'hF) ? exp_misses : exp_misses + 4'd1;
        e.served = exp_served;
        e.score  = exp_score;
        e.misses = exp_misses;
        sb_q.push_back(e);
    endtask

    task automatic load_menu(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        bus.menu_1 = a; bus.menu_2 = b; bus.menu_3 = c;
        bus.menu_valid = 1'b1;
        m[0] = a; m[1] = b; m[2] = c;
        exp_served = {c == 12'h000, b == 12'h000, a == 12'h000};
        exp_misses = 4'd0;
        step();
        bus.menu_valid = 1'b0;
        checks++;
        if (bus.served !== exp_served) begin
            errors++;
            $display("FAIL load_served: got %b want %b", bus.served, exp_served);
        end
        checks++;
        if (bus.misses !== 4'd0 || bus.result_hit !== 1'b0) begin
            errors++;
            $display("FAIL load_clear: misses %0d hit %b want 0 0", bus.misses, bus.result_hit);
        end
    endtask

    // Press, wait for the event, check the judgement two cycles later and the HOLD length.
    task automatic submit_judged(input logic [11:0] d, input bit repress);
        exp_t e;
        bit   found = 0;
        int   n = 0;
        bus.dish   = d;
        bus.submit = 1'b1;
        model_judge(d);
        for (int i = 0; i < 30; i++) begin
            step();
            n++;
            if (dut.u_debounce.event_o === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL event_wait: no submit event within 30 cycles for dish %h", d);
            bus.submit = 1'b0;
            void'(sb_q.pop_front());
            repeat (12) step();
            return;
        end
        ev_lat = n;
        if (repress) bus.submit = 1'b0;
        step();
        if (repress) bus.submit = 1'b1;
        checks++;
        if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1: busy %b result_valid %b want 1 0", bus.busy, bus.result_valid);
        end
        step();
        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++;
            $display("FAIL t2_result_valid: got %b want 1", bus.result_valid);
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.served !== e.served || bus.result_hit !== e.hit) begin
            errors++;
            $display("FAIL verdict: served %b hit %b want %b %b", bus.served, bus.result_hit, e.served, e.hit);
        end
        checks++;
        if (bus.score !== e.score || bus.misses !== e.misses) begin
            errors++;
            $display("FAIL counters: score %0d misses %0d want %0d %0d", bus.score, bus.misses, e.score, e.misses);
        end
        if (!repress) bus.submit = 1'b0;
        repeat (7) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_last: busy %b result_valid %b want 1 0", bus.busy, bus.result_valid);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_exit: busy %b want 0", bus.busy);
        end
    endtask

    task automatic press_no_event(input logic [11:0] d, input int len);
        int pulses = 0;
        bus.dish   = d;
        bus.submit = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            if (bus.result_valid === 1'b1) pulses++;
        end
        bus.submit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.result_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL no_event_%h: result_valid pulses %0d want 0", d, pulses);
        end
    endtask

    task automatic check_done(input logic win, input string tag);
        checks++;
        if (bus.round_done !== 1'b1 || bus.round_win !== win) begin
            errors++;
            $display("FAIL %s: round_done %b round_win %b want 1 %b", tag, bus.round_done, bus.round_win, win);
        end
    endtask

    task automatic test_reset();
        bus.menu_valid = 1'b0;
        bus.menu_1 = '0; bus.menu_2 = '0; bus.menu_3 = '0;
        bus.dish = '0; bus.submit = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++;
        if ({bus.served, bus.score, bus.misses, bus.result_valid, bus.result_hit,
             bus.busy, bus.round_done, bus.round_win, bus.timed_out} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: served %b score %0d misses %0d done %b busy %b",
                     bus.served, bus.score, bus.misses, bus.round_done, bus.busy);
        end
    endtask

    task automatic test_single_hit();
        load_menu(12'h001, 12'h00F, 12'h1C0);
        submit_judged(12'h00F, 0);
        checks++;
        if (bus.round_done !== 1'b0) begin
            errors++;
            $display("FAIL single_hit_armed: round_done %b want 0", bus.round_done);
        end
    endtask

    task automatic test_serve_all();
        submit_judged(12'h1C0, 0);
        submit_judged(12'h001, 0);
        check_done(1'b1, "serve_all_win");
        checks++;
        if (bus.score !== 8'd3) begin
            errors++;
            $display("FAIL serve_all_score: got %0d want 3", bus.score);
        end
    endtask

    task automatic test_misses();
        load_menu(12'h0A1, 12'h0A2, 12'h0A3);
        for (int i = 0; i < 3; i++) begin
            submit_judged(12'h555, 0);
        end
        check_done(1'b0, "misses_lose");
        press_no_event(12'h555, 8);
        checks++;
        if (bus.misses !== 4'd3 || bus.round_done !== 1'b1) begin
            errors++;
            $display("FAIL fourth_ignored: misses %0d done %b want 3 1", bus.misses, bus.round_done);
        end
    endtask

    task automatic test_empty_slots();
        load_menu(12'h000, 12'h000, 12'h001);
        submit_judged(12'h000, 0);
        submit_judged(12'h001, 0);
        check_done(1'b1, "empty_slot_win");
        load_menu(12'h000, 12'h000, 12'h000);
        check_done(1'b1, "all_empty_win");
    endtask

    task automatic test_duplicates();
        int pulses = 0;
        load_menu(12'h010, 12'h010, 12'h200);
        submit_judged(12'h010, 0);
        submit_judged(12'h777, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.result_valid === 1'b1) pulses++;
        end
        bus.submit = 1'b0;
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL hold_press: result_valid pulses %0d want 0", pulses);
        end
        repeat (5) step();
        press_no_event(12'h200, 3);
        submit_judged(12'h010, 0);
        checks++;
        if (bus.served !== 3'b011 || bus.round_done !== 1'b0) begin
            errors++;
            $display("FAIL dup_second: served %b done %b want 011 0", bus.served, bus.round_done);
        end
    endtask

    task automatic test_menu_priority();
        int pulses = 0;
        load_menu(12'h0AA, 12'h0BB, 12'h0CC);
        bus.dish   = 12'h0AA;
        bus.submit = 1'b1;
        repeat (ev_lat) step();
        checks++;
        if (dut.u_debounce.event_o !== 1'b1) begin
            errors++;
            $display("FAIL priority_align: event %b want 1", dut.u_debounce.event_o);
        end
        load_menu(12'h0AA, 12'h000, 12'h123);
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.result_valid === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        bus.submit = 1'b0;
        checks++;
        if (pulses != 0 || bus.score !== exp_score || bus.served !== 3'b010) begin
            errors++;
            $display("FAIL menu_priority: activity %0d score %0d served %b want 0 %0d 010",
                     pulses, bus.score, bus.served, exp_score);
        end
        repeat (5) step();
    endtask

    task automatic test_reset_mid_hold();
        bit found = 0;
        load_menu(12'h0AA, 12'h000, 12'h123);
        bus.dish   = 12'h123;
        bus.submit = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dut.u_debounce.event_o === 1'b1) begin
                found = 1;
                break;
            end
        end
        repeat (4) step();
        checks++;
        if (!found || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: event %b busy %b want 1 1", found, bus.busy);
        end
        reset = 1'b1;
        bus.submit = 1'b0;
        #1;
        checks++;
        if ({bus.served, bus.score, bus.misses, bus.result_valid, bus.result_hit,
             bus.busy, bus.round_done, bus.round_win, bus.timed_out} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid_hold: served %b score %0d busy %b hit %b want all 0",
                     bus.served, bus.score, bus.busy, bus.result_hit);
        end
        step();
        reset = 1'b0;
        exp_score = 8'd0;
        sb_q.delete();
        step();
    endtask

`ifdef ORDER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        bit done = 0;
        load_menu(12'h0D1, 12'h0D2, 12'h0D3);
        for (int i = 0; i < 250; i++) begin
            step();
            n++;
            if (bus.round_done === 1'b1) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done || n != 200) begin
            errors++;
            $display("FAIL timeout_time: done %b after %0d cycles want 1 after 200", done, n);
        end
        checks++;
        if (bus.timed_out !== 1'b1 || bus.round_win !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: timed_out %b round_win %b want 1 0", bus.timed_out, bus.round_win);
        end
        load_menu(12'h0D1, 12'h0D2, 12'h0D3);
        checks++;
        if (bus.timed_out !== 1'b0 || bus.round_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: timed_out %b done %b want 0 0", bus.timed_out, bus.round_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_hit();
        test_serve_all();
        test_misses();
        test_empty_slots();
        test_duplicates();
        test_menu_priority();
        test_reset_mid_hold();
`ifdef ORDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/order_checker.md
# order_checker

Consumes the three 12-bit dish codes issued each round by the menu generator and judges the player's submitted dish (switch value) against them. It tracks which orders are served, a persistent score, and per-round misses, and declares round win/lose. It sits beside the menu drawer between the menu generator and the OLED renderer, which reads `served`/`result_*`.

## Interface
- `DISH_W`, 12, dish code width
- `SCORE_W`, 8, score width (saturating)
- `MAX_MISSES`, 3, misses per round before loss (1..15)
- `DEBOUNCE_CYCLES`, 1_000_000, stable-high cycles for a valid press
- `HOLD_CYCLES`, 50_000_000, result display hold
- `TIMEOUT_CYCLES`, 2_000_000_000, round time limit (32-bit)

Ports:
- `basys_clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `menu_valid` in 1: one-cycle pulse; latch menus, start round
- `menu_1`, `menu_2`, `menu_3` in DISH_W: order codes
- `dish` in DISH_W: player's assembled dish
- `submit` in 1: raw button
- `served` out 3: bit i = order i+1 fulfilled
- `score` out SCORE_W: total hits, persists across rounds
- `misses` out 4: wrong submissions this round
- `result_valid` out 1: one-cycle pulse per judged submission
- `result_hit` out 1: held verdict of last judgement
- `busy` out 1: high in COMPARE/HOLD
- `round_done` out 1: level, high in DONE
- `round_win` out 1: valid while `round_done`
- `timed_out` out 1: level, set when round ended by timer

## Operation
- States: IDLE, ARMED, COMPARE, HOLD, DONE. Reset → IDLE; all outputs 0.
- `menu_valid` (any state, highest priority): latch menus; `served[i]` = 1 where code == 12'h000 (empty slot); clear `misses`, `result_hit`, `round_win`, `timed_out`, timer; → ARMED, or → DONE with `round_win`=1 if all three slots empty.
- ARMED: debounced submit event → COMPARE, capturing `dish`.
- COMPARE (1 cycle): hit = captured dish ≠ 0 and equals an unserved order; lowest index wins on duplicates, only that bit set. Hit: `score`+1 (saturate at 2^SCORE_W−1). Miss: `misses`+1 (saturate 15). Pulse `result_valid`, update `result_hit` → HOLD.
- HOLD: count HOLD_CYCLES, then → DONE win if `served`==3'b111, → DONE lose if `misses` ≥ MAX_MISSES, else → ARMED.
- Submit events outside ARMED are discarded, not queued. DONE holds until `menu_valid` or reset.

## Timing
- Submit: 2-flop sync; event = debounced level rising, one per press; press must be high DEBOUNCE_CYCLES consecutive cycles.
- Event in cycle t (ARMED) → COMPARE at t+1 → `result_valid`, `served`, `score`, `misses` updated at t+2; `busy` high from t+1.
- HOLD lasts exactly HOLD_CYCLES cycles; next state visible at t+2+HOLD_CYCLES.
- `menu_valid` coinciding with a submit event: menu wins; event dropped.
- Reset mid-round: immediate return to IDLE, score cleared.

## Configuration
- `ORDER_TIMEOUT_EN` defined: 32-bit timer runs in ARMED/COMPARE/HOLD from round start; at TIMEOUT_CYCLES−1 → DONE, `round_win`=0, `timed_out`=1 (pending COMPARE result still applied first). `menu_valid` clears timer.
- Undefined: no timer logic; `timed_out` tied 0; TIMEOUT_CYCLES unused.

## Structure
- Package `order_pkg`: state enum, `DISH_EMPTY`=12'h000, score/miss widths, miss saturation value.
- Sub-module `btn_debounce`: sync, debounce counter, rising-edge pulse; parameter DEBOUNCE_CYCLES.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=200.
- Menus 0x001/0x00F/0x1C0, submit 0x00F → `result_valid` 2 cycles after event, `served`=3'b010, `score`=1, `result_hit`=1.
- Serve all three in any order → `round_done`=1, `round_win`=1 after final HOLD; `score`=3.
- Three submits of 0x555 → `misses`=3, `round_done`=1, `round_win`=0; fourth submit ignored.
- Menus 0x000/0x000/0x001 → `served`=3'b011 at load; submit 0x000 → miss; submit 0x001 → win. All-zero menu → DONE win immediately.
- Duplicate menus 0x010/0x010/0x200, submit 0x010 twice → `served` 001 then 011; 3-cycle glitch press → no event; press during HOLD → no event.
- With `ORDER_TIMEOUT_EN`: no submits for 200 cycles → `timed_out`=1, `round_win`=0; `menu_valid` clears it. Reset mid-HOLD → all outputs 0.
